// File: rtl/the_demux_switch_2_pkg.sv
// Shared CPU datapath definitions for the write-side register demux.
// Provides the default bus width, the register-index constants R0..R3 and
// the two-state commit FSM encoding.
// No ports (package). No configuration macros.
package cpu_pkg;

  localparam int CPU_DATA_W = 8;

  localparam logic [1:0] REG_R0 = 2'd0;
  localparam logic [1:0] REG_R1 = 2'd1;
  localparam logic [1:0] REG_R2 = 2'd2;
  localparam logic [1:0] REG_R3 = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/the_demux_switch_2_if.sv
// Bus interface of the write-side register demux.
// Signals:
//   I9, I8     destination select (MSB, LSB); {I9,I8} = 00..11 -> R0..R3
//   input_x    write data
//   wr_valid   write request
//   wr_ready   block can accept a write
//   wr_done    one-cycle commit pulse
//   output_R0..output_R3  working registers
//   wr_err     (only with DEMUX_R0_LOCK_EN) pulses when a write targets R0
// Modports: master = CPU control side, slave = the_demux_switch_2.
// Configuration macro: DEMUX_R0_LOCK_EN.
interface the_demux_switch_2_if #(
  parameter int DATA_W = 8
);

  logic              I9;
  logic              I8;
  logic [DATA_W-1:0] input_x;
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_done;
  logic [DATA_W-1:0] output_R0;
  logic [DATA_W-1:0] output_R1;
  logic [DATA_W-1:0] output_R2;
  logic [DATA_W-1:0] output_R3;
`ifdef DEMUX_R0_LOCK_EN
  logic              wr_err;
`endif

  modport master (
    output I9, I8, input_x, wr_valid,
    input  wr_ready, wr_done, output_R0, output_R1, output_R2, output_R3
`ifdef DEMUX_R0_LOCK_EN
    , input wr_err
`endif
  );

  modport slave (
    input  I9, I8, input_x, wr_valid,
    output wr_ready, wr_done, output_R0, output_R1, output_R2, output_R3
`ifdef DEMUX_R0_LOCK_EN
    , output wr_err
`endif
  );

endinterface

// File: rtl/the_demux_switch_2_decoder.sv
// the_demux_decoder: 2-to-4 one-hot write-enable decode of the held
// destination select, gated by the COMMIT state.
// Ports:
//   sel  [1:0]  held destination select
//   en          high while the FSM is in COMMIT
//   we   [3:0]  one-hot write enables for R0..R3 (all zero when en=0)
module the_demux_decoder
  import cpu_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] we
);

  always_comb begin
    we = 4'b0000;
    if (en) begin
      unique case (sel)
        REG_R0:  we = 4'b0001;
        REG_R1:  we = 4'b0010;
        REG_R2:  we = 4'b0100;
        default: we = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/the_demux_switch_2.sv
// the_demux_switch_2: write-side counterpart of the 2-bit register-select
// mux. A write (input_x, {I9,I8}) is accepted with a valid/ready handshake,
// held for one cycle and committed into one of four working registers.
// Ports:
//   sys_clk  system clock, rising edge
//   sys_rst  synchronous active-high reset
//   bus      the_demux_switch_2_if.slave (select, data, handshake,
//            wr_done, output_R0..R3, optional wr_err)
// Configuration macro: DEMUX_R0_LOCK_EN -- R0 becomes read-only, writes to
// it complete the handshake but are discarded and raise wr_err.
module the_demux_switch_2
  import cpu_pkg::*;
#(
  parameter int                DATA_W  = CPU_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  the_demux_switch_2_if.slave  bus
);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        hold_sel;
  logic [3:0]        we_dec;
  logic [3:0]        we;
  logic [DATA_W-1:0] regs [4];
  logic              done_q;
  logic              accept;
  logic              commit;

  assign accept = bus.wr_valid && (state == ST_IDLE);
  assign commit = (state == ST_COMMIT);

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (bus.wr_valid) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: ready straight from the state; done is registered so it
  // lines up with the register update and is suppressed when reset kills a
  // pending commit.
  always_comb begin
    bus.wr_ready = (state == ST_IDLE);
    bus.wr_done  = done_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_data <= '0;
      hold_sel  <= REG_R0;
    end else if (accept) begin
      hold_data <= bus.input_x;
      hold_sel  <= {bus.I9, bus.I8};
    end
  end

  the_demux_decoder u_decoder (
    .sel (hold_sel),
    .en  (commit),
    .we  (we_dec)
  );

`ifdef DEMUX_R0_LOCK_EN
  logic err_q;

  // R0 is locked: its enable is dropped, the attempt is flagged instead.
  assign we = {we_dec[3:1], 1'b0};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) err_q <= 1'b0;
    else         err_q <= commit && (hold_sel == REG_R0);
  end

  assign bus.wr_err = err_q;
`else
  assign we = we_dec;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) done_q <= 1'b0;
    else         done_q <= commit;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) regs[i] <= hold_data;
      end
    end
  end

  assign bus.output_R0 = regs[0];
  assign bus.output_R1 = regs[1];
  assign bus.output_R2 = regs[2];
  assign bus.output_R3 = regs[3];

endmodule
